// File: rtl/aes_pkg.sv
// Shared AES round constants, MixColumns sequencer FSM encoding and GF(2^8) xtime.
// Pure declarations (no latency); no flow control.
// No handshake of its own; imported by the round blocks.
package aes_pkg;

  localparam int          AES_STATE_W = 128;
  localparam int          AES_COL_W   = 32;
  localparam int          AES_BYTE_W  = 8;
  localparam logic [7:0]  AES_POLY    = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mixcol_state_t;

  function automatic logic [AES_BYTE_W-1:0] xtime(input logic [AES_BYTE_W-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Single-column MixColumns (forward, plus inverse when MIXCOL_INV_EN is defined).
// Purely combinational, zero cycles.
// No handshake; the caller owns sequencing and flow control.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
`ifdef MIXCOL_INV_EN
  input  logic                 inv_i,
`endif
  output logic [AES_COL_W-1:0] col_o
);

  logic [AES_BYTE_W-1:0] a   [4];
  logic [AES_BYTE_W-1:0] x2  [4];
  logic [AES_BYTE_W-1:0] fwd [4];
`ifdef MIXCOL_INV_EN
  logic [AES_BYTE_W-1:0] x4  [4];
  logic [AES_BYTE_W-1:0] x8  [4];
  logic [AES_BYTE_W-1:0] inv [4];
`endif

  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col_i[AES_COL_W-1-AES_BYTE_W*r -: AES_BYTE_W];
      x2[r] = xtime(a[r]);
`ifdef MIXCOL_INV_EN
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
`endif
    end
    for (int r = 0; r < 4; r++) begin
      // b_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3)
      fwd[r] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
`ifdef MIXCOL_INV_EN
      // 0E = 8^4^2, 0B = 8^2^1, 0D = 8^4^1, 09 = 8^1
      inv[r] = (x8[r] ^ x4[r] ^ x2[r])
             ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
             ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
             ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      col_o[AES_COL_W-1-AES_BYTE_W*r -: AES_BYTE_W] = inv_i ? inv[r] : fwd[r];
`else
      col_o[AES_COL_W-1-AES_BYTE_W*r -: AES_BYTE_W] = fwd[r];
`endif
    end
  end

endmodule

// File: rtl/mixcol_sequencer.sv
// Sequenced MixColumns: one shared column mixer, one column per cycle; MIXCOL_INV_EN adds inverse mode.
// Latency 4 cycles accept-to-out_valid; initiation interval 6 cycles.
// in_ready only in IDLE; result held stable in DONE until out_ready.
module mixcol_sequencer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
`ifdef MIXCOL_INV_EN
  input  logic                   in_inv,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  mixcol_state_t          state_q, state_d;
  logic [1:0]             col_q, col_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic [AES_STATE_W-1:0] result_q, result_d;
`ifdef MIXCOL_INV_EN
  logic                   mode_q, mode_d;
`endif

  logic [AES_COL_W-1:0]   mix_in;
  logic [AES_COL_W-1:0]   mix_out;

  always_comb begin
    mix_in = '0;
    case (col_q)
      2'd0: mix_in = work_q[127:96];
      2'd1: mix_in = work_q[95:64];
      2'd2: mix_in = work_q[63:32];
      2'd3: mix_in = work_q[31:0];
      default: mix_in = '0;
    endcase
  end

  mix_single_column u_mix (
    .col_i (mix_in),
`ifdef MIXCOL_INV_EN
    .inv_i (mode_q),
`endif
    .col_o (mix_out)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    work_d   = work_q;
    result_d = result_q;
`ifdef MIXCOL_INV_EN
    mode_d   = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
`ifdef MIXCOL_INV_EN
          mode_d  = in_inv;
`endif
          col_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        case (col_q)
          2'd0: result_d[127:96] = mix_out;
          2'd1: result_d[95:64]  = mix_out;
          2'd2: result_d[63:32]  = mix_out;
          2'd3: result_d[31:0]   = mix_out;
          default: result_d = result_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= 2'd0;
      work_q   <= '0;
      result_q <= '0;
`ifdef MIXCOL_INV_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      work_q   <= work_d;
      result_q <= result_d;
`ifdef MIXCOL_INV_EN
      mode_q   <= mode_d;
`endif
    end
  end

  // Outputs decode from state/result only, so no input-to-output paths.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = result_q;

endmodule
